// File: rtl/bp_write_ctrl.sv
// Branch-predictor cache write controller: clears all 2048 entries after reset, then
// merges two write lanes through a 4-entry FIFO into a single cache write port.
module bp_write_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        wen0,
    input  logic [10:0] w_addr0,
    input  logic [15:0] w_data0,
    input  logic        wen1,
    input  logic [10:0] w_addr1,
    input  logic [15:0] w_data1,
    output logic        c_wen,
    output logic [10:0] c_addr,
    output logic [15:0] c_data,
    output logic        busy,
    output logic        stall,
    output logic [7:0]  drop_cnt
);

    typedef enum logic {StClear, StRun} state_e;

    state_e      state_q, state_d;
    logic [10:0] clr_cnt_q, clr_cnt_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  count_q, count_d;
    logic [7:0]  drop_q, drop_d;

    logic [10:0] fifo_addr_q [4];
    logic [15:0] fifo_data_q [4];

    logic        run;
    logic        deq;
    logic        lane0_req;
    logic        lane1_req;
    logic [2:0]  space;
    logic        acc0;
    logic        acc1;
    logic [1:0]  n_drop;
    logic [8:0]  drop_sum;
    logic [1:0]  wr_ptr_lane1;

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StClear;
            clr_cnt_q <= 11'd0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            StClear: begin
                clr_cnt_d = clr_cnt_q + 11'd1;
                if (clr_cnt_q == 11'd2047) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                state_d = StRun;
            end
            default: begin
                state_d = StClear;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM outputs
    // ------------------------------------------------------------------
    always_comb begin
        c_wen  = 1'b0;
        c_addr = 11'd0;
        c_data = 16'h0000;
        busy   = 1'b0;
        stall  = 1'b0;
        unique case (state_q)
            StClear: begin
                c_wen  = 1'b1;
                c_addr = clr_cnt_q;
                c_data = 16'h0000;
                busy   = 1'b1;
                stall  = 1'b1;
            end
            StRun: begin
                c_wen  = (count_q != 3'd0);
                c_addr = fifo_addr_q[rd_ptr_q];
                c_data = fifo_data_q[rd_ptr_q];
                stall  = (count_q >= 3'd3);
            end
            default: begin
                c_wen = 1'b0;
            end
        endcase
    end

    assign drop_cnt = drop_q;

    // ------------------------------------------------------------------
    // FIFO admission
    // ------------------------------------------------------------------
    always_comb begin
        run       = (state_q == StRun);
        deq       = run && (count_q != 3'd0);
        // Same-index pair collapses onto the younger lane.
        lane0_req = wen0 && !(wen1 && (w_addr0 == w_addr1));
        lane1_req = wen1;
        // Slot freed by this cycle's dequeue is reusable.
        space     = 3'd4 - count_q + {2'b00, deq};
        acc0      = run && lane0_req && (space >= 3'd1);
        acc1      = run && lane1_req && (space >= (acc0 ? 3'd2 : 3'd1));
        n_drop    = 2'd0;
        if (run) begin
            n_drop = {1'b0, lane0_req && !acc0} + {1'b0, lane1_req && !acc1};
        end
        drop_sum     = {1'b0, drop_q} + {7'd0, n_drop};
        drop_d       = (drop_sum > 9'd255) ? 8'd255 : drop_sum[7:0];
        wr_ptr_lane1 = wr_ptr_q + {1'b0, acc0};
        wr_ptr_d     = wr_ptr_q + {1'b0, acc0} + {1'b0, acc1};
        rd_ptr_d     = rd_ptr_q + {1'b0, deq};
        count_d      = count_q + {2'b00, acc0} + {2'b00, acc1} - {2'b00, deq};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 2'd0;
            rd_ptr_q <= 2'd0;
            count_q  <= 3'd0;
            drop_q   <= 8'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && acc0) begin
            fifo_addr_q[wr_ptr_q] <= w_addr0;
            fifo_data_q[wr_ptr_q] <= w_data0;
        end
        if (!rst && acc1) begin
            fifo_addr_q[wr_ptr_lane1] <= w_addr1;
            fifo_data_q[wr_ptr_lane1] <= w_data1;
        end
    end

endmodule
